// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings for the two-master bus fabric: transfer types,
// responses, slave-select codes, data-phase owner and default-slave states.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_S0   = 2'b01;
  localparam logic [1:0] SEL_S1   = 2'b10;
  localparam logic [1:0] SEL_S2   = 2'b11;

  typedef enum logic [1:0] {OWN_NONE, OWN_M1, OWN_M2} owner_e;

  typedef enum logic [1:0] {DS_OK, DS_ERR1, DS_ERR2} ds_state_e;

  // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY get zero-wait OKAY.
  function automatic logic trans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers active transfers to unmapped space with the
// two-cycle ERROR response (wait+ERROR, then ready+ERROR).
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       hclk,
  input  logic       hresetn,
  input  logic       hready_i,
  input  logic [1:0] htrans_i,
  input  logic       sel_none_i,
  output logic       hready_o,
  output logic       hresp_o
);

  ds_state_e state_q;
  ds_state_e state_d;
  logic      accept_err;

  assign accept_err = hready_i && trans_active(htrans_i) && sel_none_i;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= DS_OK;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_OK:   if (accept_err) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = accept_err ? DS_ERR1 : DS_OK;
      default: state_d = DS_OK;
    endcase
  end

  // Outputs depend on state only, so the global hready fed back in cannot loop.
  assign hready_o = (state_q != DS_ERR1);
  assign hresp_o  = (state_q == DS_OK) ? HRESP_OKAY : HRESP_ERROR;

endmodule

// File: rtl/ahb_bus_mux.sv
// Two-master AHB-lite bus mux: address phase follows the live grant, write
// data and the slave return path follow registered data-phase ownership.
module ahb_bus_mux
  import ahb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          hgrant_1,
  input  logic          hgrant_2,
  input  logic [1:0]    sel,
  input  logic [AW-1:0] haddr_1,
  input  logic [AW-1:0] haddr_2,
  input  logic [1:0]    htrans_1,
  input  logic [1:0]    htrans_2,
  input  logic          hwrite_1,
  input  logic          hwrite_2,
  input  logic [2:0]    hsize_1,
  input  logic [2:0]    hsize_2,
  input  logic [DW-1:0] hwdata_1,
  input  logic [DW-1:0] hwdata_2,
  output logic [AW-1:0] haddr,
  output logic [1:0]    htrans,
  output logic          hwrite,
  output logic [2:0]    hsize,
  output logic [DW-1:0] hwdata,
  output logic [2:0]    hsel,
  input  logic [DW-1:0] hrdata_s0,
  input  logic [DW-1:0] hrdata_s1,
  input  logic [DW-1:0] hrdata_s2,
  input  logic          hreadyout_s0,
  input  logic          hreadyout_s1,
  input  logic          hreadyout_s2,
  input  logic          hresp_s0,
  input  logic          hresp_s1,
  input  logic          hresp_s2,
  output logic [DW-1:0] hrdata,
  output logic          hready,
  output logic          hresp
);

  owner_e     addr_owner;
  owner_e     dp_owner_q;
  logic [1:0] dp_slave_q;
  logic       dp_active_q;
  logic       addr_active;
  logic       ds_hready;
  logic       ds_hresp;

  // Master 1 wins if the arbiter ever grants both.
  always_comb begin
    addr_owner = OWN_NONE;
    haddr      = '0;
    htrans     = HTRANS_IDLE;
    hwrite     = 1'b0;
    hsize      = 3'b000;
    if (hgrant_1) begin
      addr_owner = OWN_M1;
      haddr      = haddr_1;
      htrans     = htrans_1;
      hwrite     = hwrite_1;
      hsize      = hsize_1;
    end else if (hgrant_2) begin
      addr_owner = OWN_M2;
      haddr      = haddr_2;
      htrans     = htrans_2;
      hwrite     = hwrite_2;
      hsize      = hsize_2;
    end
  end

  assign addr_active = trans_active(htrans);

  for (genvar gi = 0; gi < 3; gi++) begin : g_hsel
    assign hsel[gi] = addr_active && (sel == 2'(gi + 1));
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dp_owner_q  <= OWN_NONE;
      dp_slave_q  <= SEL_NONE;
      dp_active_q <= 1'b0;
    end else if (hready) begin
      dp_owner_q  <= addr_owner;
      dp_slave_q  <= sel;
      dp_active_q <= addr_active;
    end
  end

  always_comb begin
    hwdata = '0;
    case (dp_owner_q)
      OWN_M1:  hwdata = hwdata_1;
      OWN_M2:  hwdata = hwdata_2;
      default: hwdata = '0;
    endcase
  end

  // Return path is steered by the registered slave, never the live select.
  always_comb begin
    hrdata = '0;
    hready = ds_hready;
    hresp  = ds_hresp;
    case (dp_slave_q)
      SEL_S0: begin
        hrdata = hrdata_s0;
        hready = hreadyout_s0;
        hresp  = hresp_s0;
      end
      SEL_S1: begin
        hrdata = hrdata_s1;
        hready = hreadyout_s1;
        hresp  = hresp_s1;
      end
      SEL_S2: begin
        hrdata = hrdata_s2;
        hready = hreadyout_s2;
        hresp  = hresp_s2;
      end
      default: begin
        hrdata = '0;
        hready = ds_hready;
        hresp  = ds_hresp;
      end
    endcase
  end

  ahb_default_slave u_default_slave (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .hready_i   (hready),
    .htrans_i   (htrans),
    .sel_none_i (sel == SEL_NONE),
    .hready_o   (ds_hready),
    .hresp_o    (ds_hresp)
  );

  // dp_active_q records whether the current data phase is a real transfer.
  logic unused_dp_active;
  assign unused_dp_active = dp_active_q;

  a_single_grant : assert property (@(posedge hclk) disable iff (!hresetn)
                                    !(hgrant_1 && hgrant_2));

endmodule
